// File: rtl/ctrl_pkg.sv
// Shared definitions for the transmit/receive sequencer:
// FSM state encoding, default parameters and a width helper.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_BURST,
        S_TX_DONE,
        S_RE_CAPTURE,
        S_RE_DONE
    } state_t;

    localparam int PULSE_NUM_DEF   = 8;
    localparam int HALF_PERIOD_DEF = 50;
    localparam int DEAD_DEF        = 2;
    localparam int SAMPLE_NUM_DEF  = 1024;
    localparam int SAMPLE_DIV_DEF  = 10;
    localparam int ADC_W           = 12;

    // Counter width for a parameter, never below one bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pulse_gen.sv
// Burst timing: phase counter over one drive period plus a
// pulse counter; presents the drive levels for the next cycle.
module pulse_gen
    import ctrl_pkg::*;
#(
    parameter int PULSE_NUM   = PULSE_NUM_DEF,
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int DEAD        = DEAD_DEF
) (
    input  logic clk_100,
    input  logic rst_n,
    input  logic clr,
    input  logic start,
    input  logic run,
    output logic p_nxt,
    output logic n_nxt,
    output logic done
);

    localparam int PHW = cw(2 * HALF_PERIOD);
    localparam int PCW = cw(PULSE_NUM);

    localparam logic [PHW-1:0] PH_LAST = PHW'(2 * HALF_PERIOD - 1);
    localparam logic [PHW-1:0] P_END   = PHW'(HALF_PERIOD - DEAD);
    localparam logic [PHW-1:0] N_BEG   = PHW'(HALF_PERIOD);
    localparam logic [PHW-1:0] N_END   = PHW'(2 * HALF_PERIOD - DEAD);
    localparam logic [PCW-1:0] PC_LAST = PCW'(PULSE_NUM - 1);

    logic [PHW-1:0] phase;
    logic [PHW-1:0] phase_nxt;
    logic [PCW-1:0] pcnt;
    logic [PCW-1:0] pcnt_nxt;
    logic           wrap;

    // Advance phase/pulse counts; done marks the final burst cycle.
    always_comb begin
        wrap      = (phase == PH_LAST);
        done      = wrap && (pcnt == PC_LAST);
        phase_nxt = phase;
        pcnt_nxt  = pcnt;
        if (start) begin
            phase_nxt = '0;
            pcnt_nxt  = '0;
        end else if (run && !done) begin
            phase_nxt = wrap ? '0 : phase + 1'b1;
            if (wrap) begin
                pcnt_nxt = pcnt + 1'b1;
            end
        end
        p_nxt = (phase_nxt < P_END);
        n_nxt = (phase_nxt >= N_BEG) && (phase_nxt < N_END);
    end

    // Counter registers, cleared by reset or abort.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            pcnt  <= '0;
        end else if (clr) begin
            phase <= '0;
            pcnt  <= '0;
        end else begin
            phase <= phase_nxt;
            pcnt  <= pcnt_nxt;
        end
    end

endmodule

// File: rtl/tx_re_seq.sv
// Transducer burst / receive-window sequencer with registered
// outputs, edge-triggered requests and FIFO overflow tracking.
module tx_re_seq
    import ctrl_pkg::*;
#(
    parameter int PULSE_NUM   = PULSE_NUM_DEF,
    parameter int HALF_PERIOD = HALF_PERIOD_DEF,
    parameter int DEAD        = DEAD_DEF,
    parameter int SAMPLE_NUM  = SAMPLE_NUM_DEF,
    parameter int SAMPLE_DIV  = SAMPLE_DIV_DEF
) (
    input  logic             clk_100,
    input  logic             rst_n,
    input  logic             enTx,
    input  logic             enRe,
    input  logic             fifo_rst,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             fifo_full,
    output logic             tx_p,
    output logic             tx_n,
    output logic             overTx,
    output logic             overRe,
    output logic             fifo_wr_en,
    output logic [ADC_W-1:0] fifo_din,
    output logic             busy,
    output logic             err_overflow
);

    localparam int DW = cw(SAMPLE_DIV);
    localparam int SW = cw(SAMPLE_NUM);

    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [DW-1:0] DIV_INIT = DW'(1);
    localparam logic [SW-1:0] S_LAST   = SW'(SAMPLE_NUM - 1);

    state_t           state;
    state_t           state_n;
    logic             en_tx_q;
    logic             en_re_q;
    logic             primed;
    logic             rise_tx;
    logic             rise_re;
    logic             pg_start;
    logic             pg_run;
    logic             pg_p;
    logic             pg_n;
    logic             pg_done;
    logic [DW-1:0]    div;
    logic [DW-1:0]    div_n;
    logic [SW-1:0]    scnt;
    logic [SW-1:0]    scnt_n;
    logic             fin;
    logic             fin_n;
    logic             tx_p_n;
    logic             tx_n_n;
    logic             otx_n;
    logic             ore_n;
    logic             wr_n;
    logic [ADC_W-1:0] din_n;
    logic             err_n;
    logic             busy_n;

    // A level already high when reset releases is not an edge.
    assign rise_tx  = primed && enTx && !en_tx_q && !fifo_rst;
    assign rise_re  = primed && enRe && !en_re_q && !fifo_rst;
    assign pg_start = (state == S_IDLE) && rise_tx;
    assign pg_run   = (state == S_TX_BURST) && enTx && !fifo_rst;

    pulse_gen #(
        .PULSE_NUM   (PULSE_NUM),
        .HALF_PERIOD (HALF_PERIOD),
        .DEAD        (DEAD)
    ) u_pulse_gen (
        .clk_100 (clk_100),
        .rst_n   (rst_n),
        .clr     (fifo_rst),
        .start   (pg_start),
        .run     (pg_run),
        .p_nxt   (pg_p),
        .n_nxt   (pg_n),
        .done    (pg_done)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_n = state;
        tx_p_n  = 1'b0;
        tx_n_n  = 1'b0;
        otx_n   = 1'b0;
        ore_n   = 1'b0;
        wr_n    = 1'b0;
        din_n   = fifo_din;
        err_n   = err_overflow;
        div_n   = div;
        scnt_n  = scnt;
        fin_n   = fin;
        if (fifo_rst) begin
            state_n = S_IDLE;
            din_n   = '0;
            err_n   = 1'b0;
            div_n   = '0;
            scnt_n  = '0;
            fin_n   = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (rise_tx) begin
                        state_n = S_TX_BURST;
                        tx_p_n  = pg_p;
                        tx_n_n  = pg_n;
                    end else if (rise_re) begin
                        state_n = S_RE_CAPTURE;
                        err_n   = 1'b0;
                        div_n   = DIV_INIT;
                        scnt_n  = '0;
                        fin_n   = 1'b0;
                    end
                end
                S_TX_BURST: begin
                    if (!enTx) begin
                        state_n = S_IDLE;
                    end else if (pg_done) begin
                        state_n = S_TX_DONE;
                        otx_n   = 1'b1;
                    end else begin
                        tx_p_n = pg_p;
                        tx_n_n = pg_n;
                    end
                end
                S_TX_DONE: begin
                    if (!enTx) begin
                        state_n = S_IDLE;
                    end else begin
                        otx_n = 1'b1;
                    end
                end
                S_RE_CAPTURE: begin
                    if (!enRe) begin
                        state_n = S_IDLE;
                    end else if (fin) begin
                        state_n = S_RE_DONE;
                        ore_n   = 1'b1;
                    end else if (div == DIV_LAST) begin
                        div_n = '0;
                        if (fifo_full) begin
                            err_n = 1'b1;
                        end else begin
                            wr_n  = 1'b1;
                            din_n = adc_data;
                        end
                        if (scnt == S_LAST) begin
                            fin_n = 1'b1;
                        end else begin
                            scnt_n = scnt + 1'b1;
                        end
                    end else begin
                        div_n = div + 1'b1;
                    end
                end
                S_RE_DONE: begin
                    if (!enRe) begin
                        state_n = S_IDLE;
                    end else begin
                        ore_n = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
        busy_n = (state_n != S_IDLE);
    end

    // State, edge-detect, counter and output registers.
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            en_tx_q      <= 1'b0;
            en_re_q      <= 1'b0;
            primed       <= 1'b0;
            div          <= '0;
            scnt         <= '0;
            fin          <= 1'b0;
            tx_p         <= 1'b0;
            tx_n         <= 1'b0;
            overTx       <= 1'b0;
            overRe       <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_din     <= '0;
            busy         <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state        <= state_n;
            en_tx_q      <= enTx;
            en_re_q      <= enRe;
            primed       <= 1'b1;
            div          <= div_n;
            scnt         <= scnt_n;
            fin          <= fin_n;
            tx_p         <= tx_p_n;
            tx_n         <= tx_n_n;
            overTx       <= otx_n;
            overRe       <= ore_n;
            fifo_wr_en   <= wr_n;
            fifo_din     <= din_n;
            busy         <= busy_n;
            err_overflow <= err_n;
        end
    end

endmodule

// File: tb/tb_tx_re_seq.sv
// Scoreboard bench: scenarios queue expected output events,
// a negedge monitor pops and compares every output change.
module tb_tx_re_seq;

    localparam logic [6:0] M_B  = 7'b1000000;
    localparam logic [6:0] M_P  = 7'b0100000;
    localparam logic [6:0] M_N  = 7'b0010000;
    localparam logic [6:0] M_OT = 7'b0001000;
    localparam logic [6:0] M_OR = 7'b0000100;
    localparam logic [6:0] M_W  = 7'b0000010;
    localparam logic [6:0] M_E  = 7'b0000001;

    typedef struct {
        int         cyc;
        logic [6:0] obs;
        logic [11:0] din;
    } ev_t;

    logic        clk_100 = 1'b0;
    logic        rst_n;
    logic        enTx;
    logic        enRe;
    logic        fifo_rst;
    logic [11:0] adc_data;
    logic        fifo_full;
    logic        tx_p;
    logic        tx_n;
    logic        overTx;
    logic        overRe;
    logic        fifo_wr_en;
    logic [11:0] fifo_din;
    logic        busy;
    logic        err_overflow;

    int   cyc  = 0;
    int   nchk = 0;
    int   nerr = 0;
    int   t0;
    ev_t  expq[$];
    logic [6:0] prev = '0;
    logic [6:0] obs;

    tx_re_seq #(
        .PULSE_NUM   (2),
        .HALF_PERIOD (4),
        .DEAD        (1),
        .SAMPLE_NUM  (4),
        .SAMPLE_DIV  (3)
    ) dut (
        .clk_100      (clk_100),
        .rst_n        (rst_n),
        .enTx         (enTx),
        .enRe         (enRe),
        .fifo_rst     (fifo_rst),
        .adc_data     (adc_data),
        .fifo_full    (fifo_full),
        .tx_p         (tx_p),
        .tx_n         (tx_n),
        .overTx       (overTx),
        .overRe       (overRe),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_din     (fifo_din),
        .busy         (busy),
        .err_overflow (err_overflow)
    );

    always #5 clk_100 = ~clk_100;

    always @(posedge clk_100) cyc <= cyc + 1;

    // ADC ramp: value equals the current cycle number.
    always @(posedge clk_100) begin
        #1;
        adc_data = 12'(cyc);
    end

    // Monitor: every output change or write strobe is one event.
    always @(negedge clk_100) begin
        ev_t e;
        obs = {busy, tx_p, tx_n, overTx, overRe, fifo_wr_en, err_overflow};
        if (obs !== prev || fifo_wr_en === 1'b1) begin
            nchk++;
            if (expq.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_event cyc=%0d got=%b din=%0d",
                         cyc, obs, fifo_din);
            end else begin
                e = expq.pop_front();
                if (e.cyc != cyc || e.obs !== obs ||
                    (fifo_wr_en === 1'b1 && e.din !== fifo_din)) begin
                    nerr++;
                    $display("FAIL event got cyc=%0d obs=%b din=%0d want cyc=%0d obs=%b din=%0d",
                             cyc, obs, fifo_din, e.cyc, e.obs, e.din);
                end
            end
        end
        prev = obs;
    end

    task automatic exp_ev(input int c, input logic [6:0] o,
                          input logic [11:0] d = '0);
        ev_t e;
        e.cyc = c;
        e.obs = o;
        e.din = d;
        expq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_100);
            #1;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(posedge clk_100);
            #1;
            n++;
        end
        if (expq.size() != 0) begin
            nchk++;
            nerr++;
            $display("FAIL drain_timeout pending=%0d", expq.size());
            expq.delete();
        end
        repeat (4) @(posedge clk_100);
        #1;
    endtask

    // PULSE_NUM=2, HALF_PERIOD=4, DEAD=1 burst from an edge at t.
    task automatic exp_burst(input int t);
        exp_ev(t + 1,  M_B | M_P);
        exp_ev(t + 4,  M_B);
        exp_ev(t + 5,  M_B | M_N);
        exp_ev(t + 8,  M_B);
        exp_ev(t + 9,  M_B | M_P);
        exp_ev(t + 12, M_B);
        exp_ev(t + 13, M_B | M_N);
        exp_ev(t + 16, M_B);
        exp_ev(t + 17, M_B | M_OT);
        exp_ev(t + 21, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        enTx      = 1'b1;
        enRe      = 1'b0;
        fifo_rst  = 1'b0;
        fifo_full = 1'b0;
        adc_data  = '0;

        // Reset values, with enTx already high through reset.
        @(posedge clk_100);
        #1;
        chk("reset_outs",
            {25'd0, busy, tx_p, tx_n, overTx, overRe, fifo_wr_en,
             err_overflow}, 32'd0);
        chk("reset_din", {20'd0, fifo_din}, 32'd0);
        repeat (2) @(posedge clk_100);
        #1;
        rst_n = 1'b1;
        goto(cyc + 4);
        chk("level_after_reset", {31'd0, busy}, 32'd0);
        enTx = 1'b0;
        goto(cyc + 3);

        // Full burst, overTx held until enTx drops.
        t0 = cyc;
        enTx = 1'b1;
        exp_burst(t0);
        goto(t0 + 20);
        enTx = 1'b0;
        drain(40);

        // Receive window with ramp data.
        t0 = cyc;
        enRe = 1'b1;
        exp_ev(t0 + 1,  M_B);
        exp_ev(t0 + 3,  M_B | M_W, 12'(t0 + 2));
        exp_ev(t0 + 4,  M_B);
        exp_ev(t0 + 6,  M_B | M_W, 12'(t0 + 5));
        exp_ev(t0 + 7,  M_B);
        exp_ev(t0 + 9,  M_B | M_W, 12'(t0 + 8));
        exp_ev(t0 + 10, M_B);
        exp_ev(t0 + 12, M_B | M_W, 12'(t0 + 11));
        exp_ev(t0 + 13, M_B | M_OR);
        exp_ev(t0 + 16, '0);
        goto(t0 + 15);
        enRe = 1'b0;
        drain(40);

        // Same window with the second slot dropped.
        t0 = cyc;
        enRe = 1'b1;
        exp_ev(t0 + 1,  M_B);
        exp_ev(t0 + 3,  M_B | M_W, 12'(t0 + 2));
        exp_ev(t0 + 4,  M_B);
        exp_ev(t0 + 6,  M_B | M_E);
        exp_ev(t0 + 9,  M_B | M_W | M_E, 12'(t0 + 8));
        exp_ev(t0 + 10, M_B | M_E);
        exp_ev(t0 + 12, M_B | M_W | M_E, 12'(t0 + 11));
        exp_ev(t0 + 13, M_B | M_OR | M_E);
        exp_ev(t0 + 16, M_E);
        goto(t0 + 5);
        fifo_full = 1'b1;
        goto(t0 + 7);
        fifo_full = 1'b0;
        goto(t0 + 15);
        enRe = 1'b0;
        drain(40);
        chk("overflow_sticky", {31'd0, err_overflow}, 32'd1);

        // New window clears err; fifo_rst aborts mid-window.
        t0 = cyc;
        enRe = 1'b1;
        exp_ev(t0 + 1, M_B);
        exp_ev(t0 + 3, M_B | M_E);
        exp_ev(t0 + 5, '0);
        goto(t0 + 2);
        fifo_full = 1'b1;
        goto(t0 + 3);
        fifo_full = 1'b0;
        goto(t0 + 4);
        fifo_rst = 1'b1;
        goto(t0 + 5);
        fifo_rst = 1'b0;
        goto(t0 + 10);
        enRe = 1'b0;
        drain(40);

        // enTx dropped at cycle 6 aborts the burst.
        t0 = cyc;
        enTx = 1'b1;
        exp_ev(t0 + 1, M_B | M_P);
        exp_ev(t0 + 4, M_B);
        exp_ev(t0 + 5, M_B | M_N);
        exp_ev(t0 + 7, '0);
        goto(t0 + 6);
        enTx = 1'b0;
        drain(40);

        // Simultaneous requests, plus an enRe edge mid-burst.
        t0 = cyc;
        enTx = 1'b1;
        enRe = 1'b1;
        exp_burst(t0);
        goto(t0 + 3);
        enRe = 1'b0;
        goto(t0 + 5);
        enRe = 1'b1;
        goto(t0 + 20);
        enTx = 1'b0;
        goto(t0 + 26);
        enRe = 1'b0;
        drain(40);

        // Asynchronous reset in the middle of a burst.
        t0 = cyc;
        enTx = 1'b1;
        exp_ev(t0 + 1, M_B | M_P);
        exp_ev(t0 + 2, '0);
        goto(t0 + 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_txp", {31'd0, tx_p}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        goto(t0 + 4);
        rst_n = 1'b1;
        goto(t0 + 8);
        enTx = 1'b0;
        drain(40);
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
